carregador_programa: RTL and testbench

Boot loader that sits directly upstream of the single-cycle RISC-V core. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into instruction memory through that memory's write port, and holds the core in reset until a complete, checksum-verified image is loaded.

---
 rtl/carregador_programa.sv | 127 ++++++++++++
 tb/tb_carregador_programa.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// Boot loader: receives a byte-stream program image, writes little-endian words into
// instruction memory and releases the core only after the checksum matches.
module carregador_programa #(
    parameter int PROF = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inicio,
    input  logic [7:0]  byte_in,
    input  logic        byte_valido,
    output logic        byte_pronto,
    output logic        mem_h_esc,
    output logic [5:0]  mem_ender,
    output logic [31:0] mem_dado,
    output logic        cpu_rst,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro
);

    // Handshake: a byte moves on a rising edge where byte_valido and byte_pronto are both 1;
    // byte_pronto depends on the state register only, and the producer holds byte_in until taken.
    typedef enum logic [2:0] {
        OCIOSO, CONTAGEM, DADOS, ESCRITA, CHECKSUM, FIM, ERRO
    } estado_t;

    localparam logic [8:0] PROF_MAX = 9'(PROF);

    estado_t     estado, prox;
    logic [7:0]  n_pal;
    logic [7:0]  idx;
    logic [7:0]  soma;
    logic [1:0]  nb;
    logic [23:0] palavra;
    logic        aceita;
    logic        reinicia;

    assign aceita   = byte_valido && byte_pronto;
    assign reinicia = inicio && (estado == OCIOSO || estado == FIM || estado == ERRO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO, FIM, ERRO: if (inicio) prox = CONTAGEM;
            CONTAGEM: if (aceita) begin
                if (byte_in == 8'd0 || {1'b0, byte_in} > PROF_MAX) prox = ERRO;
                else                                              prox = DADOS;
            end
            DADOS:    if (aceita && nb == 2'd3) prox = ESCRITA;
            ESCRITA:  prox = ((idx + 8'd1) == n_pal) ? CHECKSUM : DADOS;
            CHECKSUM: if (aceita) prox = (byte_in == soma) ? FIM : ERRO;
            default:  prox = OCIOSO;
        endcase
    end

    always_comb begin
        byte_pronto = 1'b0;
        mem_h_esc   = 1'b0;
        ocupado     = 1'b0;
        concluido   = 1'b0;
        erro        = 1'b0;
        cpu_rst     = 1'b1;
        case (estado)
            CONTAGEM, DADOS, CHECKSUM: begin
                byte_pronto = 1'b1;
                ocupado     = 1'b1;
            end
            ESCRITA: begin
                mem_h_esc = 1'b1;
                ocupado   = 1'b1;
            end
            FIM:     begin
                concluido = 1'b1;
                cpu_rst   = 1'b0;
            end
            ERRO:    erro = 1'b1;
            default: ;
        endcase
    end

    // Address/data are loaded on the edge that takes the 4th byte so they are already
    // stable throughout ESCRITA, and they simply hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_pal     <= 8'd0;
            idx       <= 8'd0;
            soma      <= 8'd0;
            nb        <= 2'd0;
            palavra   <= 24'd0;
            mem_ender <= 6'd0;
            mem_dado  <= 32'd0;
        end else begin
            if (reinicia) begin
                idx  <= 8'd0;
                nb   <= 2'd0;
                soma <= 8'd0;
            end
            case (estado)
                CONTAGEM: if (aceita) begin
                    n_pal <= byte_in;
                    soma  <= byte_in;
                end
                DADOS: if (aceita) begin
                    soma <= soma + byte_in;
                    nb   <= nb + 2'd1;
                    case (nb)
                        2'd0: palavra[7:0]   <= byte_in;
                        2'd1: palavra[15:8]  <= byte_in;
                        2'd2: palavra[23:16] <= byte_in;
                        default: begin
                            mem_ender <= {idx[3:0], 2'b00};
                            mem_dado  <= {byte_in, palavra};
                        end
                    endcase
                end
                ESCRITA: idx <= idx + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: drives program streams and checks every memory
// write against a queue of expected {address, word} pairs plus the final status.
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inicio = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valido = 1'b0;
    logic        byte_pronto;
    logic        mem_h_esc;
    logic [5:0]  mem_ender;
    logic [31:0] mem_dado;
    logic        cpu_rst;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [37:0] exp_q[$];
    logic [7:0]  stream_q[$];
    logic        prev_esc = 1'b0;

    carregador_programa #(.PROF(16)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .byte_in(byte_in),
        .byte_valido(byte_valido), .byte_pronto(byte_pronto),
        .mem_h_esc(mem_h_esc), .mem_ender(mem_ender), .mem_dado(mem_dado),
        .cpu_rst(cpu_rst), .ocupado(ocupado), .concluido(concluido), .erro(erro)
    );

    always #5 clk = ~clk;

    // Write monitor: every write pulse is popped against the expected queue.
    always @(negedge clk) begin
        if (mem_h_esc) begin
            logic [37:0] e;
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL unexpected_write: got @%0h=%08h, expected no write", mem_ender, mem_dado);
            end else begin
                e = exp_q.pop_front();
                if ({mem_ender, mem_dado} !== e) begin
                    n_mismatched++;
                    $display("FAIL write: got @%0h=%08h, expected @%0h=%08h",
                             mem_ender, mem_dado, e[37:32], e[31:0]);
                end
            end
            n_compared++;
            if (byte_pronto !== 1'b0 || prev_esc) begin
                n_mismatched++;
                $display("FAIL escrita_cycle: byte_pronto=%b prev_esc=%b, expected 0/0", byte_pronto, prev_esc);
            end
        end
        prev_esc = mem_h_esc;
    end

    task automatic pulse_inicio();
        inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        n_compared++;
        if (ocupado !== 1'b1 || cpu_rst !== 1'b1) begin
            n_mismatched++;
            $display("FAIL inicio: ocupado=%b cpu_rst=%b, expected 1/1", ocupado, cpu_rst);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int cyc);
        logic ok;
        ok = 1'b0;
        cyc = 0;
        byte_in = b;
        byte_valido = 1'b1;
        while (!ok && cyc < 40) begin
            @(negedge clk);
            ok = byte_pronto;
            @(posedge clk); #1;
            cyc++;
        end
        if (!ok) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL byte_timeout: byte %02h not taken in %0d cycles, expected taken", b, cyc);
        end
    endtask

    task automatic send_stream(input bit gaps, output int total);
        int cyc;
        total = 0;
        foreach (stream_q[i]) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                byte_valido = 1'b0;
                byte_in = 8'($urandom);
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            send_byte(stream_q[i], cyc);
            total += cyc;
        end
        byte_valido = 1'b0;
        stream_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_compared++;
        if ({cpu_rst, byte_pronto, mem_h_esc, ocupado, concluido, erro, mem_ender, mem_dado} !== {1'b1, 43'd0}) begin
            n_mismatched++;
            $display("FAIL reset_held: cpu_rst=%b rdy=%b esc=%b ocup=%b conc=%b erro=%b end=%0h dado=%08h, expected 1 and zeros",
                     cpu_rst, byte_pronto, mem_h_esc, ocupado, concluido, erro, mem_ender, mem_dado);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({cpu_rst, byte_pronto, mem_h_esc, ocupado, concluido, erro, mem_ender, mem_dado} !== {1'b1, 43'd0}) begin
            n_mismatched++;
            $display("FAIL reset_release: cpu_rst=%b rdy=%b ocup=%b conc=%b erro=%b, expected 1 and zeros",
                     cpu_rst, byte_pronto, ocupado, concluido, erro);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        int tot;
        exp_q.push_back({6'd0, 32'h0000_0013});
        stream_q = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        pulse_inicio();
        send_stream(1'b0, tot);
        @(negedge clk);
        n_compared++;
        if (concluido !== 1'b1 || cpu_rst !== 1'b0 || erro !== 1'b0 || ocupado !== 1'b0 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL single_word: conc=%b cpu_rst=%b erro=%b ocup=%b pending=%0d, expected 1/0/0/0/0",
                     concluido, cpu_rst, erro, ocupado, exp_q.size());
        end
        n_compared++;
        if (tot != 7) begin
            n_mismatched++;
            $display("FAIL single_word_cycles: got %0d, expected 7", tot);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_two_word(input bit gaps);
        int tot;
        exp_q.push_back({6'd0, 32'h0050_0093});
        exp_q.push_back({6'd4, 32'h0010_0113});
        stream_q = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
        pulse_inicio();
        send_stream(gaps, tot);
        @(negedge clk);
        n_compared++;
        if (concluido !== 1'b1 || cpu_rst !== 1'b0 || erro !== 1'b0 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL two_word(gaps=%0d): conc=%b cpu_rst=%b erro=%b pending=%0d, expected 1/0/0/0",
                     gaps, concluido, cpu_rst, erro, exp_q.size());
        end
        if (!gaps) begin
            n_compared++;
            if (tot != 12) begin
                n_mismatched++;
                $display("FAIL back_to_back_cycles: got %0d, expected 12", tot);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_checksum();
        int tot;
        exp_q.push_back({6'd0, 32'h0050_0093});
        exp_q.push_back({6'd4, 32'h0010_0113});
        stream_q = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h0A};
        pulse_inicio();
        send_stream(1'b0, tot);
        repeat (3) @(negedge clk);
        n_compared++;
        if (erro !== 1'b1 || cpu_rst !== 1'b1 || concluido !== 1'b0 || byte_pronto !== 1'b0 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL bad_checksum: erro=%b cpu_rst=%b conc=%b rdy=%b pending=%0d, expected 1/1/0/0/0",
                     erro, cpu_rst, concluido, byte_pronto, exp_q.size());
        end
        @(posedge clk); #1;
        test_two_word(1'b0);
    endtask

    task automatic test_bad_count();
        logic [7:0] counts[2];
        int tot;
        counts[0] = 8'h00;
        counts[1] = 8'h11;
        foreach (counts[k]) begin
            stream_q.push_back(counts[k]);
            pulse_inicio();
            send_stream(1'b0, tot);
            repeat (2) @(negedge clk);
            n_compared++;
            if (erro !== 1'b1 || cpu_rst !== 1'b1 || ocupado !== 1'b0 || byte_pronto !== 1'b0) begin
                n_mismatched++;
                $display("FAIL bad_count_%02h: erro=%b cpu_rst=%b ocup=%b rdy=%b, expected 1/1/0/0",
                         counts[k], erro, cpu_rst, ocupado, byte_pronto);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_depth(input bit gaps);
        logic [31:0] w;
        logic [7:0]  sum;
        int tot;
        sum = 8'd16;
        stream_q.push_back(8'd16);
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            exp_q.push_back({6'(i * 4), w});
            for (int j = 0; j < 4; j++) begin
                stream_q.push_back(w[j*8 +: 8]);
                sum = sum + w[j*8 +: 8];
            end
        end
        stream_q.push_back(sum);
        pulse_inicio();
        send_stream(gaps, tot);
        @(negedge clk);
        n_compared++;
        if (concluido !== 1'b1 || cpu_rst !== 1'b0 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL full_depth: conc=%b cpu_rst=%b pending=%0d, expected 1/0/0",
                     concluido, cpu_rst, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int tot;
        stream_q = '{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_inicio();
        send_stream(1'b0, tot);
        rst = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({cpu_rst, byte_pronto, mem_h_esc, ocupado, concluido, erro, mem_ender, mem_dado} !== {1'b1, 43'd0}) begin
            n_mismatched++;
            $display("FAIL abort_reset: cpu_rst=%b esc=%b ocup=%b end=%0h dado=%08h, expected 1 and zeros",
                     cpu_rst, mem_h_esc, ocupado, mem_ender, mem_dado);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_two_word(1'b0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_word(1'b0);
        test_bad_checksum();
        test_bad_count();
        test_two_word(1'b1);
        test_full_depth(1'b0);
        test_full_depth(1'b1);
        test_abort();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
